// File: rtl/fir_pkg.sv
// Constants shared by the filter datapath and its output stage: sample width,
// default decimation and warm-up, and output FIFO depth.
package fir_pkg;

  localparam int FIR_DATA_W = 16;
  localparam int FIR_DECIM  = 4;
  localparam int FIR_WARMUP = 4;
  localparam int FIR_DEPTH  = 8;

  // Width of a counter that must hold every value 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO (DEPTH a power of two); rd_data comes straight from storage, a push is readable next cycle.
// Backpressure: a push while full is accepted only together with a pop; a pop while empty is ignored.
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (do_pop && !do_push) level <= level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/fir_out_decimator.sv
// Drops WARMUP post-reset samples, keeps every DECIM-th one into a FIFO; kept sample visible one cycle later.
// Backpressure via m_valid/m_ready; a kept sample arriving while full with no pop is dropped and sets sticky overflow.
module fir_out_decimator
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DECIM  = FIR_DECIM,
  parameter int WARMUP = FIR_WARMUP,
  parameter int DEPTH  = FIR_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      din,
  input  logic                   din_valid,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int PH_W = cnt_w(DECIM - 1);
  localparam int WU_W = cnt_w(WARMUP);

  logic [PH_W-1:0] phase;
  logic [WU_W-1:0] wu_cnt;
  logic            warm_done;
  logic            keep_vld;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;

  // With WARMUP=0 the counter sits at its terminal value from reset.
  assign warm_done = (wu_cnt == WU_W'(WARMUP));
  assign keep_vld  = din_valid && warm_done && (phase == '0);
  assign pop       = m_valid && m_ready;
  assign m_valid   = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= '0;
      wu_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (din_valid) begin
        if (!warm_done)                        wu_cnt <= wu_cnt + WU_W'(1);
        else if (phase == PH_W'(DECIM - 1))    phase  <= '0;
        else                                   phase  <= phase + PH_W'(1);
      end
      if (keep_vld && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (keep_vld),
    .wr_data (din),
    .pop     (pop),
    .rd_data (m_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

endmodule
